iir_chan_sched: RTL and testbench
=================================

Name: iir_chan_sched

Overview:
Time-multiplexed scheduler for the first-order shift-add IIR section y[n] = x[n] + 3/4·x[n-1] + 9/16·y[n-1], shared among CH input channels. Round-robin arbitrates per-channel valid/ready sample streams into one compute slot. Holds per-channel filter state (x_prev, y_prev). Returns results tagged with channel number through a valid/ready output.

Parameters:
W, 14, sample MSB index; all samples are W+1 bits, two's complement
CH, 4, number of channels (2..16)
CW, 2, channel tag width; 2^CW >= CH required

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset
s_valid  in  CH  per-channel sample valid
s_ready  out  CH  per-channel accept; at most one bit high per cycle
s_data  in  CH*(W+1)  channel i sample at bits [i*(W+1)+W : i*(W+1)]
clr  in  CH  per-channel state clear pulse (zeroes x_prev/y_prev)
m_valid  out  1  result valid
m_ready  in  1  downstream accept
m_data  out  W+1  filtered sample y
m_ch  out  CW  channel of m_data

Behaviour:
- Reset (reset=0 at posedge): m_valid=0, m_data=0, m_ch=0, stage-1 valid=0, RR pointer=0, all x_prev/y_prev=0. In-flight samples are discarded. s_ready is 0 while reset=0.
- adv = !m_valid || m_ready. This is combinational and is the pipeline advance condition.
- Arbitration (combinational):
  - Search s_valid starting at the RR pointer, wrapping modulo CH. The first set bit is the grant.
  - s_ready[g] = adv && reset, for the granted g only.
  - A handshake on s_valid[g]&&s_ready[g] sets pointer <= (g+1) mod CH.
  - No handshake: pointer holds.
- Stage 1 (accept):
  - On handshake: x_r <= sample, ch_r <= g, v1 <= 1.
  - If adv=1 and no handshake: v1 <= 0.
  - If adv=0: the stage holds.
- Stage 2 (compute/write-back), on a posedge with adv=1 and v1=1:
  - x3 = (x_prev>>>1) + (x_prev>>>2)
  - y9 = (y_prev>>>1) + (y_prev>>>4)
  - y = x_r + x3 + y9
  - All shifts are arithmetic and truncating. All sums wrap mod 2^(W+1); there is no saturation.
  - m_data <= y, m_ch <= ch_r, m_valid <= 1.
  - State write-back: x_prev[ch_r] <= x_r, y_prev[ch_r] <= y.
- Output register:
  - If adv=1 and v1=0: m_valid <= 0, and m_data/m_ch hold.
  - If m_valid=1 and m_ready=0: m_data, m_ch, stage 1 and all state hold stable.
- Latency: handshake at edge k gives m_valid=1 after edge k+1 when downstream is not stalled. Throughput is 1 sample/cycle aggregate.
- Same channel accepted on back-to-back edges: the second sample computes after the first's write-back. There is no hazard and no forwarding is needed.
- clr[i] at a posedge zeroes x_prev[i]/y_prev[i].
  - Clear wins over a simultaneous write-back to the same channel. The result is still output.
  - A channel-i sample sitting in stage 1 after the clear edge computes with zero state.
- CH=1: the grant is always channel 0 and the pointer stays 0.

Test Plan:
- Impulse, ch0 only, m_ready=1, send 1024, 0, 0 -> m_data 1024, 1344, 756, all with m_ch=0. The first result appears one cycle after its handshake.
- Negative input, ch1, send -16 then 0 -> m_data -16, then -12 + (-8 + -1) = -21.
- All four s_valid held high with constant data, m_ready=1 -> grants cycle 0,1,2,3,0,…, one per cycle. m_ch matches, and each channel's sequence equals an independent single-channel reference model.
- Backpressure: m_ready=0 for 5 cycles while m_valid=1 -> s_ready=0, m_data/m_ch stable. On release, no sample is lost or duplicated and order is preserved.
- clr[2] pulsed on the same edge as a ch2 write-back, then ch2 sends 0 -> that result is 0 (state was cleared). The clear-edge result itself is still emitted.
- Wrap: ch0 sends 16383 repeatedly (W=14) -> sums wrap mod 2^15 and match a bit-exact model with no saturation. Assert reset=0 mid-stream -> m_valid=0 next cycle, and the next sample behaves as the first from zero state.

Source files
------------

// File: rtl/iir_chan_sched.sv
// Round-robin time-multiplexed first-order shift-add IIR: y = x + 3/4 x[n-1] + 9/16 y[n-1].
// Per-channel filter state lives in register arrays; results leave tagged with their channel.
module iir_chan_sched #(
   parameter int W  = 14,
   parameter int CH = 4,
   parameter int CW = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CH-1:0]         s_valid,
   output logic [CH-1:0]         s_ready,
   input  logic [CH*(W+1)-1:0]   s_data,
   input  logic [CH-1:0]         clr,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [W:0]            m_data,
   output logic [CW-1:0]         m_ch
);

   logic                 adv_s;
   logic                 found_s;
   logic                 hs_s;
   logic [CW-1:0]        grant_s;
   logic [CW-1:0]        ptr_nxt_s;
   logic [CW:0]          idx_s;
   logic [CH-1:0]        s_ready_s;
   logic signed [W:0]    sample_s;
   logic signed [W:0]    xp_s;
   logic signed [W:0]    yp_s;
   logic signed [W:0]    x3_s;
   logic signed [W:0]    y9_s;
   logic signed [W:0]    y_s;

   logic [CW-1:0]        ptr_r;
   logic                 v1_r;
   logic signed [W:0]    x_r;
   logic [CW-1:0]        ch_r;
   logic                 m_valid_r;
   logic [W:0]           m_data_r;
   logic [CW-1:0]        m_ch_r;
   logic signed [W:0]    x_prev_r [CH];
   logic signed [W:0]    y_prev_r [CH];

   assign adv_s   = !m_valid_r || m_ready;
   assign hs_s    = found_s && adv_s && reset;
   assign s_ready = s_ready_s;
   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign m_ch    = m_ch_r;

   // rotating-priority search over s_valid starting at the pointer
   always_comb begin
      found_s = 1'b0;
      grant_s = '0;
      idx_s   = '0;
      for (int k = 0; k < CH; k++) begin
         idx_s = {1'b0, ptr_r} + (CW+1)'(k);
         if (idx_s >= (CW+1)'(CH)) begin
            idx_s = idx_s - (CW+1)'(CH);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && s_valid[idx_s[CW-1:0]]) begin
            found_s = 1'b1;
            grant_s = idx_s[CW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // grant one-hot ready, granted sample mux and next pointer
   always_comb begin
      s_ready_s = '0;
      sample_s  = '0;
      if (hs_s) begin
         s_ready_s[grant_s] = 1'b1;
      end else begin
         s_ready_s = '0;
      end
      for (int i = 0; i < CH; i++) begin
         if (grant_s == CW'(i)) begin
            sample_s = s_data[i*(W+1) +: (W+1)];
         end else begin
            sample_s = sample_s;
         end
      end
      if (grant_s == CW'(CH-1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_s + CW'(1);
      end
   end

   // shift-add filter datapath; all sums wrap at W+1 bits
   always_comb begin
      xp_s = x_prev_r[ch_r];
      yp_s = y_prev_r[ch_r];
      x3_s = (xp_s >>> 1) + (xp_s >>> 2);
      y9_s = (yp_s >>> 1) + (yp_s >>> 4);
      y_s  = x_r + x3_s + y9_s;
   end

   // round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_r <= '0;
      end else if (hs_s) begin
         ptr_r <= ptr_nxt_s;
      end
   end

   // stage 1: accepted sample and its channel
   always_ff @(posedge clk) begin
      if (!reset) begin
         v1_r <= 1'b0;
         x_r  <= '0;
         ch_r <= '0;
      end else if (hs_s) begin
         v1_r <= 1'b1;
         x_r  <= sample_s;
         ch_r <= grant_s;
      end else if (adv_s) begin
         v1_r <= 1'b0;
      end
   end

   // output register
   always_ff @(posedge clk) begin
      if (!reset) begin
         m_valid_r <= 1'b0;
         m_data_r  <= '0;
         m_ch_r    <= '0;
      end else if (adv_s && v1_r) begin
         m_valid_r <= 1'b1;
         m_data_r  <= y_s;
         m_ch_r    <= ch_r;
      end else if (adv_s) begin
         m_valid_r <= 1'b0;
      end
   end

   // per-channel state; a clear beats a same-edge write-back
   always_ff @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (!reset || clr[i]) begin
            x_prev_r[i] <= '0;
            y_prev_r[i] <= '0;
         end else if (adv_s && v1_r && (ch_r == CW'(i))) begin
            x_prev_r[i] <= x_r;
            y_prev_r[i] <= y_s;
         end
      end
   end

endmodule

// File: tb/tb_iir_chan_sched.sv
// Randomised and directed bench for iir_chan_sched against a cycle-level integer reference model.
module tb_iir_chan_sched;
   localparam int W  = 14;
   localparam int CH = 4;
   localparam int CW = 2;
   localparam int DW = W + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [CH-1:0]        s_valid;
   logic [CH-1:0]        s_ready;
   logic [CH*DW-1:0]     s_data;
   logic [CH-1:0]        clr;
   logic                 m_valid;
   logic                 m_ready;
   logic [W:0]           m_data;
   logic [CW-1:0]        m_ch;

   logic [DW-1:0]        dat_r [CH];
   int                   total_r = 0;
   int                   bad_r   = 0;

   // reference model state, plain integers
   int                   e_xp [CH];
   int                   e_yp [CH];
   int                   e_ptr;
   bit                   e_v1;
   int                   e_x;
   int                   e_ch;
   bit                   e_mv;
   logic [DW-1:0]        e_md;
   int                   e_mch;

   always #5 clk = ~clk;

   iir_chan_sched #(.W(W), .CH(CH), .CW(CW)) dut (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .clr     (clr),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_ch    (m_ch)
   );

   function automatic int wrap_dw(input int v);
      int r;
      r = v % (1 << DW);
      if (r < 0) r = r + (1 << DW);
      if (r >= (1 << (DW - 1))) r = r - (1 << DW);
      return r;
   endfunction

   function automatic int filt(input int x, input int xp, input int yp);
      return wrap_dw(x + (xp >>> 1) + (xp >>> 2) + (yp >>> 1) + (yp >>> 4));
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_r++;
      if (got !== exp) begin
         bad_r++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         e_xp[i] = 0;
         e_yp[i] = 0;
      end
      e_ptr = 0; e_v1 = 1'b0; e_x = 0; e_ch = 0;
      e_mv = 1'b0; e_md = '0; e_mch = 0;
   endtask

   // one clock: check s_ready, step model across the edge, check outputs
   task automatic run_cycle();
      int g;
      int y;
      bit found;
      bit adv;
      bit hs;
      logic [CH-1:0] exp_rdy;
      for (int i = 0; i < CH; i++) s_data[i*DW +: DW] = dat_r[i];
      #1;
      adv = !e_mv || m_ready;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < CH; k++) begin
         int c;
         c = (e_ptr + k) % CH;
         if (!found && s_valid[c]) begin
            found = 1'b1;
            g = c;
         end
      end
      hs = found && adv && (reset === 1'b1);
      exp_rdy = '0;
      if (hs) exp_rdy[g] = 1'b1;
      check_val("s_ready", 32'(s_ready), 32'(exp_rdy));
      @(posedge clk);
      if (reset !== 1'b1) begin
         model_reset();
      end else begin
         if (adv && e_v1) begin
            y = filt(e_x, e_xp[e_ch], e_yp[e_ch]);
            e_md = DW'(y);
            e_mch = e_ch;
            e_mv = 1'b1;
            e_xp[e_ch] = e_x;
            e_yp[e_ch] = y;
         end else if (adv) begin
            e_mv = 1'b0;
         end
         for (int i = 0; i < CH; i++) begin
            if (clr[i]) begin
               e_xp[i] = 0;
               e_yp[i] = 0;
            end
         end
         if (hs) begin
            e_x = int'($signed(dat_r[g]));
            e_ch = g;
            e_v1 = 1'b1;
            e_ptr = (g + 1) % CH;
         end else if (adv) begin
            e_v1 = 1'b0;
         end
      end
      #1;
      check_val("m_valid", 32'(m_valid), 32'(e_mv));
      check_val("m_data", 32'(m_data), 32'(e_md));
      check_val("m_ch", 32'(m_ch), 32'(e_mch));
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; s_valid = '0; clr = '0; m_ready = 1'b1; s_data = '0;
      for (int i = 0; i < CH; i++) dat_r[i] = '0;
      model_reset();
      @(negedge clk);
      repeat (2) run_cycle();
      check_val("rst_mvalid", 32'(m_valid), 32'd0);
      check_val("rst_mdata", 32'(m_data), 32'd0);
      reset = 1'b1;

      // impulse on channel 0
      s_valid = 4'b0001; dat_r[0] = 15'd1024;
      run_cycle();
      check_val("imp_latency", 32'(m_valid), 32'd0);
      dat_r[0] = 15'd0;
      run_cycle();
      check_val("imp0", 32'(m_data), 32'd1024);
      run_cycle();
      check_val("imp1", 32'(m_data), 32'd1344);
      s_valid = 4'b0000;
      run_cycle();
      check_val("imp2", 32'(m_data), 32'd756);
      run_cycle();

      // negative input on channel 1
      s_valid = 4'b0010; dat_r[1] = 15'h7FF0;
      run_cycle();
      dat_r[1] = 15'd0;
      run_cycle();
      check_val("neg0", 32'(m_data), 32'h0000_7FF0);
      check_val("neg0_ch", 32'(m_ch), 32'd1);
      s_valid = 4'b0000;
      run_cycle();
      check_val("neg1", 32'(m_data), 32'h0000_7FEB);

      // all channels busy, then backpressure
      s_valid = 4'b1111;
      for (int i = 0; i < CH; i++) dat_r[i] = DW'($urandom);
      repeat (12) run_cycle();
      m_ready = 1'b0;
      repeat (5) run_cycle();
      m_ready = 1'b1;
      repeat (4) run_cycle();
      s_valid = 4'b0000;
      repeat (3) run_cycle();

      // clear on the same edge as a channel-2 write-back
      s_valid = 4'b0100; dat_r[2] = 15'd500;
      run_cycle();
      s_valid = 4'b0000; clr = 4'b0100;
      run_cycle();
      check_val("clr_out_valid", 32'(m_valid), 32'd1);
      check_val("clr_out_ch", 32'(m_ch), 32'd2);
      clr = 4'b0000; s_valid = 4'b0100; dat_r[2] = 15'd0;
      run_cycle();
      s_valid = 4'b0000;
      run_cycle();
      check_val("clr_zero", 32'(m_data), 32'd0);

      // wrap-around with full-scale input, then mid-stream reset
      clr = 4'b0001;
      run_cycle();
      clr = 4'b0000; s_valid = 4'b0001; dat_r[0] = 15'd16383;
      run_cycle();
      run_cycle();
      check_val("wrap0", 32'(m_data), 32'd16383);
      run_cycle();
      check_val("wrap1", 32'(m_data), 32'd5115);
      repeat (2) run_cycle();
      reset = 1'b0;
      run_cycle();
      check_val("rst_mid", 32'(m_valid), 32'd0);
      reset = 1'b1;
      run_cycle();
      run_cycle();
      check_val("after_rst", 32'(m_data), 32'd16383);

      // randomised traffic
      for (int n = 0; n < 400; n++) begin
         s_valid = CH'($urandom);
         for (int i = 0; i < CH; i++) dat_r[i] = DW'($urandom);
         m_ready = ($urandom % 4) != 0;
         clr = (($urandom % 8) == 0) ? CH'($urandom) : '0;
         reset = ($urandom % 50) != 0;
         run_cycle();
      end

      $display("test done: total=%0d bad=%0d", total_r, bad_r);
      $finish;
   end
endmodule
